// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci generator and its consumers.
//   FIB_W       width of a binary Fibonacci term
//   BCD_DIGITS  number of packed BCD digits used to display a term
//   bcd_state_t state encoding of the binary-to-BCD converter
//   bcd_t       packed BCD word, digit 0 in bits [3:0]
//   pow10()     constant helper for elaboration-time range checks
package fib_pkg;

    localparam int FIB_W      = 16;
    localparam int BCD_DIGITS = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_t;

    typedef logic [4*BCD_DIGITS-1:0] bcd_t;

    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/fib_bcd_adjust.sv
// Double-dabble digit correction: every BCD nibble that is 5 or more gets +3
// so that the following left shift carries correctly into the next digit.
//   bcd_in   packed BCD field before the shift
//   bcd_out  corrected BCD field, ready to be shifted
module fib_bcd_adjust #(
    parameter int DIGITS = 5
) (
    input  logic [4*DIGITS-1:0] bcd_in,
    output logic [4*DIGITS-1:0] bcd_out
);

    always_comb begin
        bcd_out = bcd_in;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_in[4*i +: 4] >= 4'd5) begin
                bcd_out[4*i +: 4] = bcd_in[4*i +: 4] + 4'd3;
            end
        end
    end

endmodule

// File: rtl/fib_bcd_conv.sv
// Converts one binary Fibonacci term per handshake into packed BCD using an
// iterative shift-and-add-3 engine (one bit per clock). Terms flagged as
// overflowed skip conversion and are reported with a zero BCD value.
//   clk, rst_n                      clock, async active-low reset
//   in_valid/in_ready/in_data       upstream term handshake
//   in_overflow                     upstream term overflowed W bits
//   out_valid/out_ready/out_bcd     result handshake, digit 0 in [3:0]
//   out_overflow                    result belongs to an overflowed term
//
// state | meaning
// IDLE  | waiting for a term, in_ready=1
// SHIFT | one adjust+shift per clock, W clocks in total
// DONE  | result presented, held until out_ready
module fib_bcd_conv
    import fib_pkg::*;
#(
    parameter int W      = FIB_W,
    parameter int DIGITS = BCD_DIGITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W-1:0]        in_data,
    input  logic                in_overflow,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] out_bcd,
    output logic                out_overflow
);

    localparam int SR_W  = 4*DIGITS + W;
    localparam int CNT_W = $clog2(W + 1);
    localparam longint unsigned MAX_BIN = (64'd1 << W) - 64'd1;

    // The top digit can never receive a carry if DIGITS decimal digits
    // cover the largest W-bit value.
    if (pow10(DIGITS) <= MAX_BIN) begin : g_digits_check
        $error("fib_bcd_conv: DIGITS too small to hold 2^W-1");
    end

    bcd_state_t state, state_nxt;

    logic [SR_W-1:0]     sr;
    logic [CNT_W-1:0]    cnt;
    logic [4*DIGITS-1:0] bcd_adj;
    logic [SR_W-1:0]     sr_shift;
    logic                last_bit;

    fib_bcd_adjust #(.DIGITS(DIGITS)) u_adjust (
        .bcd_in  (sr[SR_W-1:W]),
        .bcd_out (bcd_adj)
    );

    // Adjust the BCD field first, then shift the whole register left by one.
    assign sr_shift = {bcd_adj[4*DIGITS-2:0], sr[W-1:0], 1'b0};
    assign last_bit = (cnt == CNT_W'(1));

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = in_overflow ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr           <= '0;
            cnt          <= '0;
            out_bcd      <= '0;
            out_overflow <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (in_overflow) begin
                            out_bcd      <= '0;
                            out_overflow <= 1'b1;
                        end else begin
                            sr  <= {{(4*DIGITS){1'b0}}, in_data};
                            cnt <= CNT_W'(W);
                        end
                    end
                end
                SHIFT: begin
                    sr  <= sr_shift;
                    cnt <= cnt - CNT_W'(1);
                    if (last_bit) begin
                        out_bcd      <= sr_shift[SR_W-1:W];
                        out_overflow <= 1'b0;
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fib_bcd_conv.sv
module tb_fib_bcd_conv;
    import fib_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        in_overflow = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    bcd_t        out_bcd;
    logic        out_overflow;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    fib_bcd_conv dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_overflow  (in_overflow),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_bcd      (out_bcd),
        .out_overflow (out_overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic bcd_t ref_bcd(input int unsigned v);
        bcd_t r;
        int unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Present a term until accepted; lat = edges after the accept edge until
    // out_valid is seen (0 means visible right after the accept edge).
    task automatic send(input logic [15:0] d, input logic ov, input logic hold,
                        output int lat, output int acc_cyc);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b1;
        in_data = d;
        in_overflow = ov;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        if (!hold) in_valid = 1'b0;
        in_overflow = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic take();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (out_valid !== 1'b0 || out_bcd !== 20'h0 || out_overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got valid=%b bcd=%h ovf=%b exp 0/00000/0",
                     out_valid, out_bcd, out_overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
    endtask

    task automatic test_directed();
        logic [15:0] vin  [3] = '{16'd0, 16'd55, 16'd46368};
        bcd_t        vexp [3] = '{20'h00000, 20'h00055, 20'h46368};
        int lat, acc;
        for (int i = 0; i < 3; i++) begin
            apply_reset();
            send(vin[i], 1'b0, 1'b0, lat, acc);
            checks++;
            if (lat !== 16) begin
                errors++;
                $display("FAIL directed_latency in=%0d got=%0d exp=16", vin[i], lat);
            end
            checks++;
            if (out_bcd !== vexp[i] || out_overflow !== 1'b0) begin
                errors++;
                $display("FAIL directed_bcd in=%0d got=%h ovf=%b exp=%h ovf=0",
                         vin[i], out_bcd, out_overflow, vexp[i]);
            end
            take();
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL directed_release got valid=%b ready=%b exp 0/1",
                         out_valid, in_ready);
            end
        end
    endtask

    // out_ready held high from before the result exists must not disturb it.
    task automatic test_max();
        int lat, acc;
        apply_reset();
        @(negedge clk);
        out_ready = 1'b1;
        send(16'hFFFF, 1'b0, 1'b0, lat, acc);
        checks++;
        if (lat !== 16 || out_bcd !== 20'h65535) begin
            errors++;
            $display("FAIL max_value got lat=%0d bcd=%h exp lat=16 bcd=65535", lat, out_bcd);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL max_single_beat got valid=%b exp=0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        int lat, acc;
        int bad;
        apply_reset();
        send(16'd89, 1'b0, 1'b0, lat, acc);
        // upstream keeps offering a different term while the block is busy
        in_valid = 1'b1;
        in_data = 16'd144;
        bad = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_bcd !== 20'h00089 || in_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL backpressure_hold bad_cycles=%0d exp=0 (valid=%b bcd=%h ready=%b)",
                     bad, out_valid, out_bcd, in_ready);
        end
        in_valid = 1'b0;
        take();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release got ready=%b valid=%b exp 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_overflow();
        int lat, acc;
        send(16'h1234, 1'b1, 1'b0, lat, acc);
        checks++;
        if (lat !== 0) begin
            errors++;
            $display("FAIL overflow_latency got=%0d exp=0", lat);
        end
        checks++;
        if (out_valid !== 1'b1 || out_overflow !== 1'b1 || out_bcd !== 20'h0) begin
            errors++;
            $display("FAIL overflow_result got valid=%b ovf=%b bcd=%h exp 1/1/00000",
                     out_valid, out_overflow, out_bcd);
        end
        take();
    endtask

    task automatic test_back_to_back();
        int unsigned a, b, t;
        int lat, acc, prev_acc;
        int bad_val, bad_gap;
        a = 0;
        b = 1;
        bad_val = 0;
        bad_gap = 0;
        prev_acc = -1;
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            send(16'(a), 1'b0, 1'b1, lat, acc);
            if (lat != 16 || out_bcd !== ref_bcd(a) || out_overflow !== 1'b0) begin
                bad_val++;
                $display("FAIL stream_term n=%0d in=%0d got=%h lat=%0d exp=%h lat=16",
                         i, a, out_bcd, lat, ref_bcd(a));
            end
            if (prev_acc >= 0 && acc - prev_acc != 18) bad_gap++;
            prev_acc = acc;
            t = a + b;
            a = b;
            b = t;
        end
        in_valid = 1'b0;
        checks++;
        if (bad_val != 0) begin
            errors++;
            $display("FAIL stream_values bad=%0d exp=0", bad_val);
        end
        checks++;
        if (bad_gap != 0) begin
            errors++;
            $display("FAIL stream_throughput bad_gaps=%0d exp=0", bad_gap);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int seen;
        int lat, acc;
        apply_reset();
        @(negedge clk);
        in_valid = 1'b1;
        in_data = 16'd610;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_bcd !== 20'h0 || out_overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_outputs got valid=%b bcd=%h ovf=%b exp 0/00000/0",
                     out_valid, out_bcd, out_overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid || !in_ready) seen++;
        end
        out_ready = 1'b0;
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_mid_no_result bad_cycles=%0d exp=0", seen);
        end
        send(16'd13, 1'b0, 1'b0, lat, acc);
        checks++;
        if (lat !== 16 || out_bcd !== 20'h00013) begin
            errors++;
            $display("FAIL reset_mid_next got lat=%0d bcd=%h exp lat=16 bcd=00013", lat, out_bcd);
        end
        take();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_max();
        test_backpressure();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fib_bcd_conv.md
Name: fib_bcd_conv

Overview:
Downstream consumer of the fib generator. It accepts one binary Fibonacci term per valid/ready handshake and converts it to packed BCD with an iterative double-dabble (shift-and-add-3) engine. It presents the result on a valid/ready output for the display or UART stage. It also forwards the generator's overflow flag, skipping conversion when that flag is set.

Parameters:
W, 16, width of the binary input term
DIGITS, 5, number of BCD digits; must satisfy 10^DIGITS > 2^W-1 (checked by elaboration assertion)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream term valid
in_ready  output  1  block can accept a term
in_data  input  W  binary Fibonacci term
in_overflow  input  1  upstream term overflowed W bits
out_valid  output  1  BCD result valid
out_ready  input  1  downstream accepts result
out_bcd  output  4*DIGITS  packed BCD; digit 0 in bits [3:0]
out_overflow  output  1  result corresponds to an overflowed term

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset state (asynchronous on rst_n low):
  - state=IDLE, out_valid=0, out_bcd=0, out_overflow=0
  - shift register=0, bit counter=0
  - in_ready=1 once rst_n deasserts
- FSM states: IDLE, SHIFT, DONE.
- in_ready = (state==IDLE), driven combinationally from state. It never depends on out_ready.
- IDLE:
  - On an edge with in_valid&in_ready and in_overflow=0: load {DIGITS*4'b0, in_data} into the shift register, set counter=W, go to SHIFT.
  - On the same handshake with in_overflow=1: set out_bcd=0, out_overflow=1, go straight to DONE. out_valid is visible 1 cycle after accept.
- SHIFT, once per edge:
  - Every BCD nibble >=5 gets +3 (combinational adjust).
  - Then the whole register shifts left by 1.
  - counter decrements.
  - On the edge where counter goes 1->0: latch the adjusted and shifted BCD field into out_bcd, set out_overflow=0, go to DONE.
- Latency: out_valid rises on the W-th edge after the accept edge (16 for the default).
- DONE:
  - out_valid=1. out_bcd and out_overflow are held stable until handshake.
  - On an edge with out_valid&out_ready: go to IDLE and clear out_valid.
- No overlap between output and input: max throughput is one term per W+2 cycles.
- Arithmetic:
  - Adjust and shift operate on a (4*DIGITS+W)-bit register.
  - No carry escapes the top digit, given the DIGITS constraint.
  - in_data=0 yields all-zero BCD.
  - in_data=2^W-1 must convert exactly.
- Boundary conditions:
  - in_valid held high while busy: ignored, no second capture. Upstream must hold the term per valid/ready rules.
  - in_valid dropping mid-conversion: no effect.
  - out_ready high before out_valid: no effect.
  - out_ready low indefinitely: block stalls in DONE with outputs frozen.
  - rst_n low mid-SHIFT or in DONE: the conversion is abandoned, all outputs return to reset values immediately, and no partial result is ever presented.

Decomposition:
- Shared package fib_pkg holds:
  - FIB_W (16)
  - BCD_DIGITS (5)
  - typedef enum logic [1:0] bcd_state_t {IDLE, SHIFT, DONE}
  - typedef logic [4*BCD_DIGITS-1:0] bcd_t
- One combinational sub-module, fib_bcd_adjust (parameter DIGITS): applies add-3-if->=5 to every nibble. It is instantiated once in the SHIFT datapath.

Test Plan:
- Directed conversions, each sent after reset: in_data=0 -> out_bcd=20'h00000; in_data=55 -> 20'h00055; in_data=46368 -> 20'h46368. In every case out_valid rises exactly 16 edges after accept and out_overflow=0.
- Max value: in_data=16'hFFFF -> out_bcd=20'h65535, no spurious carry.
- Backpressure: convert 89, hold out_ready=0 for 7 cycles -> out_valid stays 1, out_bcd=20'h00089 stable, in_ready=0. Raise out_ready -> in_ready=1 on the next cycle.
- Overflow: in_overflow=1 with in_data=16'h1234 -> out_valid after 1 edge, out_overflow=1, out_bcd=0.
- Back-to-back stream: drive the Fibonacci sequence 0,1,1,2,...,28657 with out_ready=1 -> every BCD output matches the reference model, one result per 18 cycles.
- Reset mid-operation: assert rst_n=0 at edge 8 of a conversion of 610 -> out_valid=0 and in_ready=1 after release, no result emitted. A following conversion of 13 -> 20'h00013.
